bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_pkg.sv | 28 ++
 rtl/bin2bcd_seq_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 tb/tb_bin2bcd_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Number of decimal digits needed to print 2^w - 1.
  function automatic int bcd_digits(int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        d++;
      end
    end
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one magnitude bit per clock, with valid/ready
// on both sides, a sign flag and a leading-zero blanking mask.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// SHIFT | double-dabble iterations running, counter counts down to 0
// DONE  | result presented on out_*, held until out_ready
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W       = 11,
  parameter int SIGNED_MODE = 0,
  localparam int DIGITS     = bcd_digits(BIN_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_neg,
  output logic [DIGITS-1:0]             out_digit_en
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  bcd_state_t state, state_next;

  logic [CNT_W-1:0]       cnt;
  logic [BIN_W-1:0]       mag;
  logic [BIN_W-1:0]       in_mag;
  logic                   in_sign;
  logic [BCD_W-1:0]       acc;
  logic [BCD_W-1:0]       acc_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   neg_q;
  logic                   accept;
  logic [DIGITS-1:0]      digit_nz;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // -2^(BIN_W-1) negates to itself, which read unsigned is the correct magnitude.
  assign in_sign = (SIGNED_MODE != 0) && in_bin[BIN_W-1];
  assign in_mag  = in_sign ? (~in_bin) + BIN_W'(1) : in_bin;

  assign shifted = {acc_adj, mag} << 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );

    assign digit_nz[g] = |out_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W];

    if (g == 0) begin : g_units
      assign out_digit_en[g] = 1'b1;
    end else begin : g_upper
      assign out_digit_en[g] = |digit_nz[DIGITS-1:g];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers are separate from out_bcd/out_neg so the last delivered
  // result stays visible while the next conversion runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mag     <= '0;
      acc     <= '0;
      neg_q   <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
    end else if (accept) begin
      mag   <= in_mag;
      acc   <= '0;
      neg_q <= in_sign;
      cnt   <= CNT_W'(BIN_W - 1);
    end else if (state == SHIFT) begin
      {acc, mag} <= shifted;
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        out_bcd <= shifted[BCD_W+BIN_W-1 -: BCD_W];
        out_neg <= neg_q & (|shifted[BCD_W+BIN_W-1 -: BCD_W]);
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations (11u, 8s, 16u) exercised in turn
// with directed corner cases and randomized traffic checked against an arithmetic model.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [39:0] bcd;
    logic        neg;
    logic [4:0]  en;
  } exp_t;

  logic        clk;
  logic        rst       [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        out_neg   [3];
  logic [31:0] in_bin    [3];
  logic [39:0] out_bcd   [3];
  logic [4:0]  out_en    [3];

  logic [15:0] bcd_a;
  logic [3:0]  en_a;
  logic [11:0] bcd_b;
  logic [2:0]  en_b;
  logic [19:0] bcd_c;
  logic [4:0]  en_c;

  assign out_bcd[0] = 40'(bcd_a);
  assign out_bcd[1] = 40'(bcd_b);
  assign out_bcd[2] = 40'(bcd_c);
  assign out_en[0]  = 5'(en_a);
  assign out_en[1]  = 5'(en_b);
  assign out_en[2]  = en_c;

  exp_t sb [3][$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq #(.BIN_W(11), .SIGNED_MODE(0)) dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_bin(in_bin[0][10:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_bcd(bcd_a), .out_neg(out_neg[0]), .out_digit_en(en_a)
  );

  bin2bcd_seq #(.BIN_W(8), .SIGNED_MODE(1)) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_bin(in_bin[1][7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_bcd(bcd_b), .out_neg(out_neg[1]), .out_digit_en(en_b)
  );

  bin2bcd_seq #(.BIN_W(16), .SIGNED_MODE(0)) dut_c (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_bin(in_bin[2][15:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_bcd(bcd_c), .out_neg(out_neg[2]), .out_digit_en(en_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int cw(int k);
    case (k)
      0:       return 11;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit cs(int k);
    return (k == 1);
  endfunction

  // Reference: plain decimal arithmetic on the two's-complement reading of the sample.
  function automatic exp_t model(logic [31:0] raw, int w, bit sgn);
    exp_t e;
    longint unsigned v, mag, p10, d;
    bit neg;
    int top;
    v   = longint'(raw) & ((64'd1 << w) - 64'd1);
    neg = sgn && (v >= (64'd1 << (w - 1)));
    mag = neg ? ((64'd1 << w) - v) : v;
    e.bcd = '0;
    p10 = 1;
    top = 0;
    for (int i = 0; i < 10; i++) begin
      d = (mag / p10) % 10;
      e.bcd[4*i +: 4] = 4'(d);
      if (d != 0) top = i;
      p10 = p10 * 10;
    end
    e.en = '0;
    for (int i = 0; i < 5; i++) if (i <= top) e.en[i] = 1'b1;
    e.neg = neg && (mag != 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_val(int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'(m);
      2:       return 32'(64'd1 << (w - 1));
      default: return 32'($urandom) & 32'(m);
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records accepted samples and checks every completed output handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        sb[k].delete();
      end else begin
        if (out_valid[k] && out_ready[k]) begin
          chk($sformatf("sb_entry_%0d", k), 64'(sb[k].size() != 0), 64'd1);
          if (sb[k].size() != 0) begin
            mon_e = sb[k].pop_front();
            chk($sformatf("bcd_%0d", k), 64'(out_bcd[k]), 64'(mon_e.bcd));
            chk($sformatf("neg_%0d", k), 64'(out_neg[k]), 64'(mon_e.neg));
            chk($sformatf("digit_en_%0d", k), 64'(out_en[k]), 64'(mon_e.en));
          end
        end
        if (in_valid[k] && in_ready[k])
          sb[k].push_back(model(in_bin[k], cw(k), cs(k)));
      end
    end
  end

  // Returns 1 ns after the accept edge.
  task automatic send(int k, logic [31:0] v);
    bit acc;
    @(posedge clk);
    #1;
    in_bin[k]   = v;
    in_valid[k] = 1'b1;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready[k] && !rst[k]) acc = 1;
      else @(posedge clk);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    chk($sformatf("accept_%0d", k), 64'(acc), 64'd1);
  endtask

  // Counts edges after the accept edge until out_valid is seen; ends on a negedge.
  task automatic wait_out(int k, output int cyc);
    bit got;
    cyc = 0;
    got = 0;
    while (!got && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid[k]) got = 1;
    end
    chk($sformatf("out_seen_%0d", k), 64'(got), 64'd1);
  endtask

  task automatic expect_out(int k, string tag, logic [39:0] bcd, logic neg, logic [4:0] en);
    chk({tag, "_bcd"}, 64'(out_bcd[k]), 64'(bcd));
    chk({tag, "_neg"}, 64'(out_neg[k]), 64'(neg));
    chk({tag, "_en"},  64'(out_en[k]),  64'(en));
  endtask

  task automatic convert(int k, string tag, logic [31:0] v, logic [39:0] bcd, logic neg,
                         logic [4:0] en);
    int cyc;
    send(k, v);
    wait_out(k, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(cw(k)));
    expect_out(k, tag, bcd, neg, en);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(out_valid[k]), 64'd0);
  endtask

  task automatic rand_phase(int k, int n);
    int  acc_n, cyc, limit;
    bit  drop;
    acc_n = 0;
    cyc   = 0;
    drop  = 0;
    limit = n * (cw(k) + 1) * 6 + 500;
    while ((acc_n < n || sb[k].size() != 0 || in_valid[k]) && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop) begin
        in_valid[k] = 1'b0;
        drop = 0;
      end
      out_ready[k] = ($urandom_range(0, 3) != 0);
      if (!in_valid[k] && acc_n < n && $urandom_range(0, 2) != 0) begin
        in_bin[k]   = rand_val(cw(k));
        in_valid[k] = 1'b1;
      end
      @(negedge clk);
      if (in_valid[k] && in_ready[k]) begin
        acc_n++;
        drop = 1;
      end
    end
    chk($sformatf("rand_accepted_%0d", k), 64'(acc_n), 64'(n));
    chk($sformatf("rand_drained_%0d", k), 64'(sb[k].size()), 64'd0);
    @(posedge clk);
    #1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk($sformatf("rand_idle_%0d", k), 64'(out_valid[k]), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic [39:0] hold;

    for (int k = 0; k < 3; k++) begin
      rst[k]       = 1'b1;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_bin[k]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_%0d", k),  64'(in_ready[k]),  64'd1);
      chk($sformatf("rst_out_valid_%0d", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("rst_bcd_%0d", k),       64'(out_bcd[k]),   64'd0);
      chk($sformatf("rst_neg_%0d", k),       64'(out_neg[k]),   64'd0);
      chk($sformatf("rst_en_%0d", k),        64'(out_en[k]),    64'd1);
    end

    // 11-bit unsigned
    out_ready[0] = 1'b1;
    convert(0, "a2047", 32'd2047, 40'h2047, 1'b0, 5'b01111);
    convert(0, "a0",    32'd0,    40'h0000, 1'b0, 5'b00001);
    convert(0, "a999",  32'd999,  40'h0999, 1'b0, 5'b00111);

    out_ready[0] = 1'b0;
    send(0, 32'd1500);
    wait_out(0, cyc);
    hold = out_bcd[0];
    chk("bp_value", 64'(hold), 64'h1500);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid",    64'(out_valid[0]), 64'd1);
      chk("bp_stable",   64'(out_bcd[0]),   64'(hold));
      chk("bp_in_ready", 64'(in_ready[0]),  64'd0);
    end
    @(posedge clk);
    #1;
    in_bin[0]    = 32'd321;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("release_gap", 64'(out_valid[0]), 64'd0);
    wait_out(0, cyc);
    chk("release_latency", 64'(cyc), 64'd11);
    expect_out(0, "a321", 40'h0321, 1'b0, 5'b00111);

    send(0, 32'd1111);
    repeat (4) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid[0]), 64'd0);
      chk("abort_in_ready", 64'(in_ready[0]),  64'd1);
    end
    convert(0, "a1234", 32'd1234, 40'h1234, 1'b0, 5'b01111);
    rand_phase(0, 300);
    out_ready[0] = 1'b0;

    // 8-bit signed
    out_ready[1] = 1'b1;
    convert(1, "b80", 32'h80, 40'h128, 1'b1, 5'b00111);
    convert(1, "bff", 32'hFF, 40'h001, 1'b1, 5'b00001);
    convert(1, "b7f", 32'h7F, 40'h127, 1'b0, 5'b00111);
    convert(1, "b00", 32'h00, 40'h000, 1'b0, 5'b00001);
    rand_phase(1, 200);
    out_ready[1] = 1'b0;

    // 16-bit unsigned
    out_ready[2] = 1'b1;
    convert(2, "c65535", 32'd65535, 40'h65535, 1'b0, 5'b11111);
    rand_phase(2, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
